// File: rtl/avalon_mem_burst_responder_if.sv
// Avalon-MM local-memory bus between the AFU-side master and the burst responder.
// The master drives commands and write beats; the slave returns read beats and waitrequest.
interface avalon_mem_burst_responder_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int BURST_CNT_WIDTH = 4
);
  logic                       waitrequest;
  logic [ADDR_WIDTH-1:0]      address;
  logic [BURST_CNT_WIDTH-1:0] burstcount;
  logic                       read;
  logic                       write;
  logic [DATA_WIDTH-1:0]      writedata;
  logic [DATA_WIDTH/8-1:0]    byteenable;
  logic [DATA_WIDTH-1:0]      readdata;
  logic                       readdatavalid;
  logic                       cmd_err;

  modport master (
    input  waitrequest, readdata, readdatavalid, cmd_err,
    output address, burstcount, read, write, writedata, byteenable
  );

  modport slave (
    output waitrequest, readdata, readdatavalid, cmd_err,
    input  address, burstcount, read, write, writedata, byteenable
  );
endinterface

// File: rtl/avalon_mem_burst_responder.sv
// Avalon-MM burst slave backed by a word-addressed RAM with fixed read latency.
// Optional forced-waitrequest injection is compiled in with AVMM_RESP_WAIT_INJECT_EN.
module avalon_mem_burst_responder #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 10,
  parameter int BURST_CNT_WIDTH    = 4,
  parameter int MEM_ADDR_WIDTH     = 8,
  parameter int READ_LATENCY       = 2,
  parameter int WAIT_INJECT_PERIOD = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  avalon_mem_burst_responder_if.slave  bus
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, WR_BURST, RD_ISSUE} state_e;

  state_e                     state_q, state_d;
  logic [BURST_CNT_WIDTH-1:0] beats_left_q, beats_left_d;
  logic [MEM_ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic                       waitrequest_q, waitrequest_d;
  logic                       cmd_err_q, cmd_err_d;
  logic                       force_wait_d;

  logic                       mem_we;
  logic [MEM_ADDR_WIDTH-1:0]  mem_waddr;
  logic                       rd_issue;
  logic [MEM_ADDR_WIDTH-1:0]  rd_addr;
  logic                       accept_rd, accept_wr;
  logic [MEM_ADDR_WIDTH-1:0]  addr_lo;
  logic                       unused_addr;

  logic [DATA_WIDTH-1:0]      mem_q [2**MEM_ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]      pipe_data_q [READ_LATENCY];
  logic                       pipe_vld_q  [READ_LATENCY];

  assign addr_lo     = bus.address[MEM_ADDR_WIDTH-1:0];
  assign unused_addr = ^bus.address;
  assign accept_rd   = bus.read  & ~waitrequest_q;
  assign accept_wr   = bus.write & ~waitrequest_q;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    beats_left_d = beats_left_q;
    next_addr_d  = next_addr_q;
    mem_we       = 1'b0;
    mem_waddr    = next_addr_q;
    rd_issue     = 1'b0;
    rd_addr      = next_addr_q;
    cmd_err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept_rd || accept_wr) begin
          if ((bus.read && bus.write) || bus.burstcount == '0) begin
            cmd_err_d = 1'b1;
          end else if (bus.write) begin
            mem_we    = 1'b1;
            mem_waddr = addr_lo;
            if (bus.burstcount != BURST_CNT_WIDTH'(1)) begin
              state_d      = WR_BURST;
              beats_left_d = bus.burstcount - 1'b1;
              next_addr_d  = addr_lo + 1'b1;
            end
          end else begin
            rd_issue = 1'b1;
            rd_addr  = addr_lo;
            if (bus.burstcount != BURST_CNT_WIDTH'(1)) begin
              state_d      = RD_ISSUE;
              beats_left_d = bus.burstcount - 1'b1;
              next_addr_d  = addr_lo + 1'b1;
            end
          end
        end
      end
      WR_BURST: begin
        // A read during a write burst is a protocol error and swallows the cycle's beat.
        if (accept_rd) begin
          cmd_err_d = 1'b1;
        end else if (accept_wr) begin
          mem_we       = 1'b1;
          next_addr_d  = next_addr_q + 1'b1;
          beats_left_d = beats_left_q - 1'b1;
          if (beats_left_q == BURST_CNT_WIDTH'(1)) state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        rd_issue     = 1'b1;
        next_addr_d  = next_addr_q + 1'b1;
        beats_left_d = beats_left_q - 1'b1;
        if (beats_left_q == BURST_CNT_WIDTH'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AVMM_RESP_WAIT_INJECT_EN
  localparam int CNT_W = $clog2(WAIT_INJECT_PERIOD);
  logic [CNT_W-1:0] inj_cnt_q, inj_cnt_d;

  assign inj_cnt_d    = (inj_cnt_q == CNT_W'(WAIT_INJECT_PERIOD - 1)) ? '0 : inj_cnt_q + 1'b1;
  assign force_wait_d = (inj_cnt_d == CNT_W'(WAIT_INJECT_PERIOD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) inj_cnt_q <= '0;
    else          inj_cnt_q <= inj_cnt_d;
  end
`else
  localparam int unused_wait_period = WAIT_INJECT_PERIOD;
  assign force_wait_d = 1'b0;
`endif

  // waitrequest is registered from next state so it never depends on request inputs.
  assign waitrequest_d = (state_d == RD_ISSUE) | force_wait_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q       <= IDLE;
      beats_left_q  <= '0;
      next_addr_q   <= '0;
      waitrequest_q <= 1'b1;
      cmd_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      beats_left_q  <= beats_left_d;
      next_addr_q   <= next_addr_d;
      waitrequest_q <= waitrequest_d;
      cmd_err_q     <= cmd_err_d;
    end
  end

  // NOTE: the RAM array has no reset; only control and pipeline registers are cleared.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (bus.byteenable[k]) mem_q[mem_waddr][8*k +: 8] <= bus.writedata[8*k +: 8];
      end
    end
  end

  // Read pipeline: stage 0 captures RAM, the last stage drives the bus; data moves only with valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i]  <= 1'b0;
        pipe_data_q[i] <= '0;
      end
    end else begin
      pipe_vld_q[0] <= rd_issue;
      if (rd_issue) pipe_data_q[0] <= mem_q[rd_addr];
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        if (pipe_vld_q[i-1]) pipe_data_q[i] <= pipe_data_q[i-1];
      end
    end
  end

  assign bus.waitrequest   = waitrequest_q;
  assign bus.readdata      = pipe_data_q[READ_LATENCY-1];
  assign bus.readdatavalid = pipe_vld_q[READ_LATENCY-1];
  assign bus.cmd_err       = cmd_err_q;
endmodule

// File: doc/avalon_mem_burst_responder.md
Name: avalon_mem_burst_responder

Overview:
- Single-clock Avalon-MM slave that is the responding end of the local-memory interface the AFU drives.
- Accepts burst reads and writes and stores data in an internal word-addressed RAM.
- Returns read bursts with fixed latency and back-pressures with waitrequest.
- Used as a local-memory bank model behind the clock-crossing shim, for simulation and for on-chip scratch memory.

Parameters:
DATA_WIDTH, 32, readdata/writedata width in bits; multiple of 8
ADDR_WIDTH, 10, word address width on the bus
BURST_CNT_WIDTH, 4, burstcount width; max burst = 2**(BURST_CNT_WIDTH-1)
MEM_ADDR_WIDTH, 8, internal RAM depth = 2**MEM_ADDR_WIDTH words; only address[MEM_ADDR_WIDTH-1:0] used; must be <= ADDR_WIDTH
READ_LATENCY, 2, cycles from RAM read issue to readdatavalid; >= 1
WAIT_INJECT_PERIOD, 8, period of forced waitrequest when the optional feature is compiled in; >= 2

Ports:
clk  in  1  clock
reset_n  in  1  reset; asynchronous, active-low
waitrequest  out  1  slave not ready; a command is accepted when (read|write) & ~waitrequest
address  in  ADDR_WIDTH  word address of first beat
burstcount  in  BURST_CNT_WIDTH  beats in burst
read  in  1  read command
write  in  1  write command/beat
writedata  in  DATA_WIDTH  write beat data
byteenable  in  DATA_WIDTH/8  per-byte write mask
readdata  out  DATA_WIDTH  read beat data
readdatavalid  out  1  readdata valid; no back-pressure
cmd_err  out  1  one-cycle pulse on a protocol error

Behaviour:
- Reset (reset_n low, async):
  - Outputs: waitrequest=1, readdatavalid=0, readdata=0, cmd_err=0.
  - Logic: state=IDLE; read pipeline valid bits cleared.
  - RAM contents are not reset.
  - waitrequest drops on the first rising clk after reset_n deasserts.
- States: IDLE, WR_BURST, RD_ISSUE. waitrequest is a function of registered state; there is no combinational path from the request inputs.
- IDLE: waitrequest=0.
  - write accepted, burstcount=B>=1:
    - beat 0 written to address.
    - B==1: stay IDLE.
    - else: go WR_BURST with beats_left=B-1 and next_addr=address+1.
  - read accepted, burstcount=B>=1:
    - RAM read of beat 0 issued the same cycle.
    - B==1: stay IDLE.
    - else: go RD_ISSUE with beats_left=B-1.
- WR_BURST: waitrequest=0.
  - Each cycle with write=1 writes writedata at next_addr and decrements beats_left; address and burstcount are ignored.
  - Return to IDLE after the cycle that writes the last beat.
  - write=0 cycles are bubbles with no state change.
- RD_ISSUE: waitrequest=1.
  - One RAM read per cycle at incrementing address.
  - Return to IDLE after the last beat is issued.
  - A read burst accepted at cycle t issues beat i at t+i and raises readdatavalid for beat i at t+i+READ_LATENCY.
  - The next command can be accepted at t+B.
- Byte writes: byte k is updated only if byteenable[k]=1.
- Address arithmetic: modulo 2**MEM_ADDR_WIDTH; the burst wraps from the top of RAM to 0.
- Ordering: a read accepted after a write burst completes returns the new data, including a write in the cycle immediately before the read.
- Errors: cmd_err pulses for exactly one cycle; the offending command or beat is consumed and ignored.
  - read & write both high in IDLE.
  - burstcount==0.
  - read asserted in WR_BURST.
- Reset mid-operation: the burst is abandoned; pending read beats in the pipeline are discarded; no readdatavalid after reset asserts.
- readdata holds its last value when readdatavalid=0.

Optional Feature:
- Macro AVMM_RESP_WAIT_INJECT_EN.
- Defined:
  - A free-running counter (reset 0) counts modulo WAIT_INJECT_PERIOD.
  - When the counter equals WAIT_INJECT_PERIOD-1, waitrequest is forced to 1 in IDLE and WR_BURST for that cycle.
  - A write beat presented that cycle is not consumed.
  - RD_ISSUE progress and readdatavalid timing are unaffected.
- Undefined: no counter is built; waitrequest follows state only.

Test Plan:
- Write burst B=4 at addr 0x10 with data 0xA0..0xA3, byteenable=0xF, then read B=4 at 0x10 accepted at t -> readdatavalid at t+2..t+5 with readdata 0xA0,0xA1,0xA2,0xA3; waitrequest=1 at t+1..t+3.
- Write 0x11223344 at addr 5, then write 0xAABBCCDD at addr 5 with byteenable=0x5 -> read at 5 returns 0x11BB33DD.
- Write B=4 at 0xFE with data 1,2,3,4 -> single reads return 0xFE=1, 0xFF=2, 0x00=3, 0x01=4.
- read=write=1 in IDLE, then a read with burstcount=0 -> cmd_err high one cycle each, no readdatavalid, state stays IDLE.
- Read B=8 accepted, reset_n low 3 cycles later -> readdatavalid=0 and waitrequest=1 immediately; after release, waitrequest=0 at the next clk and no stale beats appear.
- With AVMM_RESP_WAIT_INJECT_EN and WAIT_INJECT_PERIOD=8: continuous write=1 from reset -> waitrequest high at counter=7 (every 8th cycle); the write beat held that cycle is written exactly once.
